l2_pmem_adapter: RTL and testbench
==================================

Name: l2_pmem_adapter

Overview:
- Responder on the L2 cache's physical-memory port (pmem_read / pmem_write / pmem_resp, 256-bit line).
- Converts each whole-line request into a 4-beat, 64-bit burst on the main-memory bus.
- Completes the request with a single-cycle pmem_resp.
- Sits between the L2 cache controller/datapath and the burst DRAM model.

Parameters:
- LINE_WIDTH, 256, cache line width in bits.
- BURST_WIDTH, 64, bits per memory beat; beat count BEATS = LINE_WIDTH/BURST_WIDTH = 4.
- ADDR_WIDTH, 32, byte address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- pmem_read  in  1  line read request from L2, held until pmem_resp
- pmem_write  in  1  line write request from L2, held until pmem_resp
- pmem_address  in  ADDR_WIDTH  line address from L2
- pmem_wdata  in  LINE_WIDTH  line to write back
- pmem_rdata  out  LINE_WIDTH  assembled line returned to L2
- pmem_resp  out  1  one-cycle completion pulse to L2
- mem_read  out  1  burst read request to memory
- mem_write  out  1  burst write request to memory
- mem_address  out  ADDR_WIDTH  line-aligned burst address
- mem_wdata  out  BURST_WIDTH  current write beat
- mem_rdata  in  BURST_WIDTH  current read beat
- mem_resp  in  1  beat accepted/valid, one per beat, not necessarily consecutive

Behaviour:
- Reset (asynchronous):
  - State returns to IDLE and the beat counter to 0.
  - pmem_resp, mem_read and mem_write go to 0.
  - pmem_rdata, mem_address and mem_wdata go to 0.
  - Reset mid-burst aborts the transfer; no pmem_resp is produced; buffered data is discarded.
- States: IDLE, RD_BURST, RD_DONE, WR_BURST, WR_DONE.
- IDLE:
  - On pmem_read, latch the address, go to RD_BURST.
  - On pmem_write, latch the address and pmem_wdata into the line buffer, go to WR_BURST.
  - pmem_read and pmem_write together: the read is serviced first; the write stays pending and is accepted once back in IDLE.
  - mem_resp is ignored in IDLE.
- Latched address: mem_address = {pmem_address[ADDR_WIDTH-1:5], 5'b0}. It is held constant for the whole burst.
- RD_BURST:
  - mem_read = 1.
  - On each cycle with mem_resp = 1, mem_rdata is written into buffer bits [cnt*64 +: 64] and cnt increments.
  - On the 4th beat (cnt == 3 with mem_resp), go to RD_DONE.
  - mem_read deasserts in RD_DONE.
- RD_DONE:
  - pmem_resp = 1 for exactly one cycle; pmem_rdata equals the full assembled line.
  - cnt clears; next state IDLE.
  - pmem_rdata holds its value until the next read completes; it is not updated per beat.
- WR_BURST:
  - mem_write = 1; mem_wdata = buffer[cnt*64 +: 64], combinational from cnt.
  - cnt advances on each mem_resp.
  - On the 4th beat, go to WR_DONE; mem_write deasserts in WR_DONE.
- WR_DONE: pmem_resp = 1 for one cycle; cnt clears; next state IDLE.
- Upstream contract: L2 drops its request in the cycle after pmem_resp, so IDLE does not retrigger. The adapter imposes no extra bubble.
- Latency:
  - Request seen in IDLE at cycle 0; mem_read/mem_write asserted from cycle 1.
  - With beats at cycles 1-4 (no gaps), pmem_resp occurs at cycle 5.
  - Each gap cycle without mem_resp adds one cycle.
- mem_resp while no beat is outstanding (IDLE, RD_DONE, WR_DONE): no effect.
- Counter is 2 bits, wraps 3→0 only through the DONE state clear; beats beyond 4 are never captured.

Test Plan:
- Read, no gaps: pmem_read, pmem_address=0x0000_1234; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 at cycles 1-4.
  → mem_address=0x0000_1220; pmem_resp at cycle 5 only; pmem_rdata = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Write, gapped beats: pmem_write with pmem_wdata = {D3,D2,D1,D0}; mem_resp at cycles 1, 3, 4, 7.
  → mem_wdata shows D0, D1, D2, D3 in order; mem_write stays high through cycle 7; pmem_resp at cycle 8.
- Simultaneous request: pmem_read=1 and pmem_write=1 in IDLE.
  → Read burst runs first with pmem_resp; with pmem_write still held, the write burst starts on the next IDLE cycle.
- Reset mid-burst: assert rst after the 2nd read beat.
  → Outputs go to 0 immediately; no pmem_resp. A subsequent read returns a clean line with no stale beats.
- Spurious mem_resp=1 in IDLE for 3 cycles, then a read with 4 beats.
  → Assembled line contains only the 4 requested beats; pmem_resp fires exactly once.
- Back-to-back: write line A to 0x100, then read 0x100 from a memory model.
  → Read returns A; pmem_rdata is unchanged by the write.

Source files
------------

// File: rtl/l2_pmem_adapter.sv
// L2 physical-memory port adapter: turns each whole-line read or write into a
// BEATS-long burst on the main-memory bus and answers with a one-cycle pmem_resp.
module l2_pmem_adapter #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pmem_read,
  input  logic                   pmem_write,
  input  logic [ADDR_WIDTH-1:0]  pmem_address,
  input  logic [LINE_WIDTH-1:0]  pmem_wdata,
  output logic [LINE_WIDTH-1:0]  pmem_rdata,
  output logic                   pmem_resp,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [ADDR_WIDTH-1:0]  mem_address,
  output logic [BURST_WIDTH-1:0] mem_wdata,
  input  logic [BURST_WIDTH-1:0] mem_rdata,
  input  logic                   mem_resp
);

  localparam int BEATS    = LINE_WIDTH / BURST_WIDTH;
  localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFFSET_W = $clog2(LINE_WIDTH / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_BURST,
    RD_DONE,
    WR_BURST,
    WR_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [LINE_WIDTH-1:0]  buf_q, buf_d;
  logic [LINE_WIDTH-1:0]  rdata_q, rdata_d;

  // Byte-offset bits inside the line never reach the memory bus.
  logic unused_offset_bits;
  assign unused_offset_bits = ^pmem_address[OFFSET_W-1:0];

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    buf_d     = buf_q;
    rdata_d   = rdata_q;
    pmem_resp = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_wdata = '0;

    unique case (state_q)
      IDLE: begin
        // Read wins a simultaneous request; the held write is taken on the next IDLE.
        if (pmem_read) begin
          addr_d  = {pmem_address[ADDR_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};
          cnt_d   = '0;
          state_d = RD_BURST;
        end else if (pmem_write) begin
          addr_d  = {pmem_address[ADDR_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};
          buf_d   = pmem_wdata;
          cnt_d   = '0;
          state_d = WR_BURST;
        end
      end

      RD_BURST: begin
        mem_read = 1'b1;
        if (mem_resp) begin
          buf_d[cnt_q*BURST_WIDTH +: BURST_WIDTH] = mem_rdata;
          if (cnt_q == LAST_BEAT) begin
            // Publish the whole line at once; pmem_rdata never shows a partial line.
            rdata_d = buf_d;
            state_d = RD_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      RD_DONE: begin
        pmem_resp = 1'b1;
        cnt_d     = '0;
        state_d   = IDLE;
      end

      WR_BURST: begin
        mem_write = 1'b1;
        mem_wdata = buf_q[cnt_q*BURST_WIDTH +: BURST_WIDTH];
        if (mem_resp) begin
          if (cnt_q == LAST_BEAT) begin
            state_d = WR_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      WR_DONE: begin
        pmem_resp = 1'b1;
        cnt_d     = '0;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      // NOTE: the line buffers are cleared on reset so an aborted burst leaves no stale beats behind.
      buf_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
      rdata_q <= rdata_d;
    end
  end

  assign pmem_rdata  = rdata_q;
  assign mem_address = addr_q;

endmodule

// File: tb/tb_l2_pmem_adapter.sv
// Directed bench for l2_pmem_adapter: read/write bursts, gaps, request collision,
// reset mid-burst, spurious mem_resp and write-then-read through a small memory model.
module tb_l2_pmem_adapter;

  logic         clk;
  logic         rst;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_address;
  logic [63:0]  mem_wdata;
  logic [63:0]  mem_rdata;
  logic         mem_resp;

  l2_pmem_adapter #(
    .LINE_WIDTH (256),
    .BURST_WIDTH(64),
    .ADDR_WIDTH (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pmem_read   (pmem_read),
    .pmem_write  (pmem_write),
    .pmem_address(pmem_address),
    .pmem_wdata  (pmem_wdata),
    .pmem_rdata  (pmem_rdata),
    .pmem_resp   (pmem_resp),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_resp    (mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Word-granular memory model keyed by byte address.
  logic [63:0] mem_model [logic [31:0]];

  // Results of the most recent run_req call.
  int           resp_cyc  [$];
  logic [255:0] resp_line [$];
  int           rd_first, rd_last, rd_n;
  int           wr_first, wr_last, wr_n;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] fill(input logic [7:0] b);
    return {8{b}};
  endfunction

  task automatic load_line(input logic [31:0] base, input logic [255:0] line);
    for (int i = 0; i < 4; i++) mem_model[base + 32'(i * 8)] = line[i*64 +: 64];
  endtask

  // Presents a request from cycle 0 and answers beats per resp_pat (bit n = mem_resp in cycle n).
  // Each request is dropped in the cycle after its pmem_resp.
  task automatic run_req(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [255:0] wd, input logic [31:0] resp_pat);
    logic [31:0] base;
    int          b;
    bit          rd_pend, wr_pend, cur_rd;
    base = {addr[31:5], 5'b0};
    resp_cyc.delete();
    resp_line.delete();
    rd_first = -1; rd_last = -1; rd_n = 0;
    wr_first = -1; wr_last = -1; wr_n = 0;
    b = 0; cur_rd = 1'b0;
    rd_pend = rd; wr_pend = wr;
    pmem_read = rd; pmem_write = wr; pmem_address = addr; pmem_wdata = wd;
    for (int cyc = 0; cyc < 32 && (rd_pend || wr_pend); cyc++) begin
      mem_resp = resp_pat[cyc];
      if (mem_read && b < 4 && mem_model.exists(base + 32'(b * 8)))
        mem_rdata = mem_model[base + 32'(b * 8)];
      else
        mem_rdata = 64'hBAD0_BAD0_0000_0000 | 64'(cyc);
      @(negedge clk);
      if (mem_read) begin
        cur_rd = 1'b1;
        if (rd_first < 0) rd_first = cyc;
        rd_last = cyc;
        rd_n++;
        if (mem_resp) begin
          check("rd_addr", mem_address, base);
          if (b >= 4) check("rd_extra_beat", b, 3);
          b++;
        end
      end
      if (mem_write) begin
        cur_rd = 1'b0;
        if (wr_first < 0) wr_first = cyc;
        wr_last = cyc;
        wr_n++;
        if (mem_resp) begin
          check("wr_addr", mem_address, base);
          if (b < 4) begin
            check("wr_beat", mem_wdata, wd[b*64 +: 64]);
            mem_model[base + 32'(b * 8)] = mem_wdata;
          end else begin
            check("wr_extra_beat", b, 3);
          end
          b++;
        end
      end
      if (pmem_resp) begin
        resp_cyc.push_back(cyc);
        resp_line.push_back(pmem_rdata);
        if (cur_rd) rd_pend = 1'b0;
        else        wr_pend = 1'b0;
        b = 0;
      end
      @(posedge clk);
      #1;
      if (!rd_pend) pmem_read = 1'b0;
      if (!wr_pend) pmem_write = 1'b0;
    end
    mem_resp = 1'b0;
    pmem_read = 1'b0;
    pmem_write = 1'b0;
    check("req_timeout", {rd_pend, wr_pend}, 2'b00);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_pmem_resp"}, pmem_resp, 1'b0);
    check({tag, "_mem_read"}, mem_read, 1'b0);
    check({tag, "_mem_write"}, mem_write, 1'b0);
  endtask

  logic [255:0] line_a, line_b, line_c, line_w, line_q, line_s, line_x;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    pmem_read = 1'b0; pmem_write = 1'b0; pmem_address = '0; pmem_wdata = '0;
    mem_rdata = '0; mem_resp = 1'b0;

    line_a = {fill(8'h44), fill(8'h33), fill(8'h22), fill(8'h11)};
    line_w = {64'hD3D3_0003_D3D3_0003, 64'hD2D2_0002_D2D2_0002,
              64'hD1D1_0001_D1D1_0001, 64'hD0D0_0000_D0D0_0000};
    line_c = {fill(8'hC3), fill(8'hC2), fill(8'hC1), fill(8'hC0)};
    line_b = {fill(8'hAB), fill(8'hAA), fill(8'hA9), fill(8'hA8)};
    line_q = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
              64'h0F0F_0F0F_F0F0_F0F0, 64'h5555_AAAA_5555_AAAA};
    line_s = {fill(8'h5D), fill(8'h5C), fill(8'h5B), fill(8'h5A)};
    line_x = {64'hA5A5_0000_1111_0003, 64'hA5A5_0000_1111_0002,
              64'hA5A5_0000_1111_0001, 64'hA5A5_0000_1111_0000};
    load_line(32'h0000_1220, line_a);
    load_line(32'h0000_0600, line_c);
    load_line(32'h0000_2000, line_b);
    load_line(32'h0000_3000, line_q);
    load_line(32'h0000_5000, line_s);

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    check("reset_pmem_rdata", pmem_rdata, '0);
    check("reset_mem_address", mem_address, '0);
    check("reset_mem_wdata", mem_wdata, '0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Read with back-to-back beats.
    run_req(1'b1, 1'b0, 32'h0000_1234, '0, 32'h0000_001E);
    check("rd_resp_count", resp_cyc.size(), 1);
    check("rd_resp_cycle", resp_cyc[0], 5);
    check("rd_line", resp_line[0], line_a);
    check("rd_mem_read_first", rd_first, 1);
    check("rd_mem_read_last", rd_last, 4);
    check("rd_mem_read_cycles", rd_n, 4);
    check("rd_mem_address_hold", mem_address, 32'h0000_1220);
    @(negedge clk);
    check("rd_pmem_rdata_hold", pmem_rdata, line_a);
    check_idle_outputs("rd_after");
    @(posedge clk);
    #1;

    // Write with gapped beats at cycles 1, 3, 4, 7.
    run_req(1'b0, 1'b1, 32'h0000_0417, line_w, 32'h0000_009A);
    check("wr_resp_count", resp_cyc.size(), 1);
    check("wr_resp_cycle", resp_cyc[0], 8);
    check("wr_mem_write_first", wr_first, 1);
    check("wr_mem_write_last", wr_last, 7);
    check("wr_mem_write_cycles", wr_n, 7);
    check("wr_no_mem_read", rd_n, 0);
    check("wr_pmem_rdata_unchanged", pmem_rdata, line_a);

    // Simultaneous read and write: read burst first, write on the following IDLE cycle.
    run_req(1'b1, 1'b1, 32'h0000_0600, line_x, 32'h0000_079E);
    check("sim_resp_count", resp_cyc.size(), 2);
    check("sim_rd_resp_cycle", resp_cyc[0], 5);
    check("sim_wr_resp_cycle", resp_cyc[1], 11);
    check("sim_rd_line", resp_line[0], line_c);
    check("sim_rd_first", rd_first, 1);
    check("sim_rd_last", rd_last, 4);
    check("sim_wr_first", wr_first, 7);
    check("sim_wr_last", wr_last, 10);
    check("sim_pmem_rdata_after_wr", pmem_rdata, line_c);

    // Reset after the second read beat.
    pmem_read = 1'b1; pmem_address = 32'h0000_2008;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      mem_resp = 1'b1; mem_rdata = line_b[i*64 +: 64];
      @(posedge clk); #1;
    end
    mem_resp = 1'b0;
    @(negedge clk);
    check("rstmid_pre_mem_read", mem_read, 1'b1);
    rst = 1'b1;
    #1;
    check_idle_outputs("rstmid");
    check("rstmid_pmem_rdata", pmem_rdata, '0);
    check("rstmid_mem_address", mem_address, '0);
    check("rstmid_mem_wdata", mem_wdata, '0);
    pmem_read = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rstmid_no_resp", pmem_resp, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_req(1'b1, 1'b0, 32'h0000_3000, '0, 32'h0000_001E);
    check("rstmid_resp_count", resp_cyc.size(), 1);
    check("rstmid_clean_line", resp_line[0], line_q);

    // Spurious mem_resp while idle, then a read that also sees mem_resp in IDLE and RD_DONE.
    for (int i = 0; i < 3; i++) begin
      mem_resp = 1'b1; mem_rdata = 64'hEEEE_EEEE_0000_0000 | 64'(i);
      @(negedge clk);
      check_idle_outputs("spur_idle");
      @(posedge clk); #1;
    end
    mem_resp = 1'b0;
    run_req(1'b1, 1'b0, 32'h0000_501F, '0, 32'h0000_003F);
    check("spur_resp_count", resp_cyc.size(), 1);
    check("spur_resp_cycle", resp_cyc[0], 5);
    check("spur_line", resp_line[0], line_s);
    @(negedge clk);
    check("spur_no_second_resp", pmem_resp, 1'b0);
    @(posedge clk); #1;

    // Write line to 0x100, then read it back through the model.
    run_req(1'b0, 1'b1, 32'h0000_0100, line_x ^ line_a, 32'h0000_001E);
    check("b2b_wr_resp_cycle", resp_cyc[0], 5);
    check("b2b_rdata_unchanged", pmem_rdata, line_s);
    run_req(1'b1, 1'b0, 32'h0000_0100, '0, 32'h0000_001E);
    check("b2b_rd_resp_count", resp_cyc.size(), 1);
    check("b2b_rd_line", resp_line[0], line_x ^ line_a);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
